// File: rtl/d_sram_like_bridge_if.sv
// Data-side SRAM-like bus between the CPU core bridge (master) and the cache/AXI bridge (slave).
interface d_sram_like_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [DATA_W-1:0] data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/d_sram_like_bridge.sv
// Issues the M-stage load/store as one SRAM-like bus transaction and stalls the core until it completes.
// Optional D_BRIDGE_PERF_EN adds saturating accepted-request and stall-cycle counters.
module d_sram_like_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_enM,
    input  logic [3:0]        mem_wenM,
    input  logic [1:0]        mem_sizeM,
    input  logic [ADDR_W-1:0] data_addrM,
    input  logic [DATA_W-1:0] writedataM,
    input  logic              flush_exceptM,
    input  logic              longest_stall,
    output logic [DATA_W-1:0] mem_rdataM2,
    output logic              d_stall,
`ifdef D_BRIDGE_PERF_EN
    output logic [31:0]       perf_acc_cnt,
    output logic [31:0]       perf_stall_cnt,
`endif
    d_sram_like_bridge_if.master bus
);

    typedef enum logic [1:0] {IDLE, WAIT_ADDR, WAIT_DATA, DONE} state_t;

    state_t state;
    logic   kill_q;
    logic   rd_q;
    logic   start;
    logic   killed;

    assign start  = mem_enM & ~flush_exceptM;
    assign killed = kill_q | flush_exceptM;

    // The M-stage inputs are frozen by d_stall, so the request fields come straight from them.
    assign bus.data_wr    = |mem_wenM;
    assign bus.data_addr  = data_addrM;
    assign bus.data_wdata = writedataM;

    always_comb begin
        // NOTE: default every always_comb output first so no path infers a latch.
        bus.data_size = mem_sizeM;
        if (|mem_wenM) begin
            case (mem_wenM)
                4'b1111:          bus.data_size = 2'd2;
                4'b0011, 4'b1100: bus.data_size = 2'd1;
                default:          bus.data_size = 2'd0;
            endcase
        end
    end

    // Request is withdrawn the same cycle a flush hits, since it was not yet accepted.
    always_comb begin
        bus.data_req = 1'b0;
        d_stall      = 1'b0;
        case (state)
            IDLE: begin
                bus.data_req = start;
                d_stall      = start;
            end
            WAIT_ADDR: begin
                bus.data_req = start;
                d_stall      = 1'b1;
            end
            WAIT_DATA: d_stall = 1'b1;
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            kill_q      <= 1'b0;
            rd_q        <= 1'b0;
            mem_rdataM2 <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        rd_q  <= ~bus.data_wr;
                        state <= bus.data_addr_ok ? WAIT_DATA : WAIT_ADDR;
                    end
                end
                WAIT_ADDR: begin
                    if (!start)
                        state <= IDLE;
                    else if (bus.data_addr_ok)
                        state <= WAIT_DATA;
                end
                WAIT_DATA: begin
                    if (flush_exceptM)
                        kill_q <= 1'b1;
                    // An accepted request always runs to completion; a killed one is dropped here.
                    if (bus.data_data_ok) begin
                        if (!killed && rd_q)
                            mem_rdataM2 <= bus.data_rdata;
                        kill_q <= 1'b0;
                        state  <= killed ? IDLE : DONE;
                    end
                end
                DONE: begin
                    if (!longest_stall)
                        state <= IDLE;
                end
            endcase
        end
    end

`ifdef D_BRIDGE_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_acc_cnt   <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (bus.data_req && bus.data_addr_ok && perf_acc_cnt != '1)
                perf_acc_cnt <= perf_acc_cnt + 32'd1;
            if (d_stall && perf_stall_cnt != '1)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

    a_no_ok_pair_idle: assert property (@(posedge clk) disable iff (rst)
        (state == IDLE) |-> !(bus.data_addr_ok && bus.data_data_ok));

    a_data_ok_in_wait: assert property (@(posedge clk) disable iff (rst)
        bus.data_data_ok |-> (state == WAIT_DATA));

endmodule

// File: tb/tb_d_sram_like_bridge.sv
// Directed bench for d_sram_like_bridge: combinational field-mapping table plus multi-cycle bus sequences.
module tb_d_sram_like_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_enM;
    logic [3:0]  mem_wenM;
    logic [1:0]  mem_sizeM;
    logic [31:0] data_addrM;
    logic [31:0] writedataM;
    logic        flush_exceptM;
    logic        longest_stall;
    logic [31:0] mem_rdataM2;
    logic        d_stall;
`ifdef D_BRIDGE_PERF_EN
    logic [31:0] perf_acc_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    int bus_acc = 0;

    d_sram_like_bridge_if bus_if ();

    d_sram_like_bridge dut (
        .clk           (clk),
        .rst           (rst),
        .mem_enM       (mem_enM),
        .mem_wenM      (mem_wenM),
        .mem_sizeM     (mem_sizeM),
        .data_addrM    (data_addrM),
        .writedataM    (writedataM),
        .flush_exceptM (flush_exceptM),
        .longest_stall (longest_stall),
        .mem_rdataM2   (mem_rdataM2),
        .d_stall       (d_stall),
`ifdef D_BRIDGE_PERF_EN
        .perf_acc_cnt  (perf_acc_cnt),
        .perf_stall_cnt(perf_stall_cnt),
`endif
        .bus           (bus_if.master)
    );

    always #5 clk = ~clk;

    // Independent count of requests accepted on the bus.
    always @(posedge clk)
        if (!rst && bus_if.data_req && bus_if.data_addr_ok)
            bus_acc++;

    typedef struct {
        logic        en;
        logic [3:0]  wen;
        logic [1:0]  size;
        logic        flush;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_req;
        logic        exp_stall;
        logic        exp_wr;
        logic [1:0]  exp_size;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_m(input logic en, input logic [3:0] wen, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata);
        mem_enM    = en;
        mem_wenM   = wen;
        mem_sizeM  = size;
        data_addrM = addr;
        writedataM = wdata;
    endtask

    initial begin
        int acc0;
        rst = 1'b1;
        drive_m(1'b0, 4'b0000, 2'd0, 32'h0, 32'h0);
        flush_exceptM        = 1'b0;
        longest_stall        = 1'b0;
        bus_if.data_addr_ok  = 1'b0;
        bus_if.data_data_ok  = 1'b0;
        bus_if.data_rdata    = 32'h0;

        // ---------------- reset state ----------------
        step(); step();
        rst = 1'b0;
        #1;
        chk("reset_rdata", mem_rdataM2, 32'h0);
        chk1("reset_stall", d_stall, 1'b0);
        chk1("reset_req", bus_if.data_req, 1'b0);

        // ---------------- field-mapping table (IDLE, addr_ok low) ----------------
        vecs[0] = '{1'b1, 4'b0000, 2'd2, 1'b0, 32'h8000_0010, 32'h1111_1111, 1'b1, 1'b1, 1'b0, 2'd2};
        vecs[1] = '{1'b1, 4'b0000, 2'd0, 1'b0, 32'h8000_0003, 32'h2222_2222, 1'b1, 1'b1, 1'b0, 2'd0};
        vecs[2] = '{1'b1, 4'b0000, 2'd1, 1'b0, 32'h8000_0006, 32'h3333_3333, 1'b1, 1'b1, 1'b0, 2'd1};
        vecs[3] = '{1'b1, 4'b0100, 2'd2, 1'b0, 32'h8000_0012, 32'h5A5A_5A5A, 1'b1, 1'b1, 1'b1, 2'd0};
        vecs[4] = '{1'b1, 4'b1100, 2'd0, 1'b0, 32'h8000_0022, 32'hABCD_ABCD, 1'b1, 1'b1, 1'b1, 2'd1};
        vecs[5] = '{1'b1, 4'b0011, 2'd2, 1'b0, 32'h8000_0020, 32'h1234_1234, 1'b1, 1'b1, 1'b1, 2'd1};
        vecs[6] = '{1'b1, 4'b1111, 2'd0, 1'b0, 32'h8000_0030, 32'hCAFE_BABE, 1'b1, 1'b1, 1'b1, 2'd2};
        vecs[7] = '{1'b1, 4'b0001, 2'd2, 1'b0, 32'h8000_0041, 32'h7777_7777, 1'b1, 1'b1, 1'b1, 2'd0};
        vecs[8] = '{1'b1, 4'b0000, 2'd2, 1'b1, 32'h8000_0050, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 2'd2};
        vecs[9] = '{1'b0, 4'b1000, 2'd1, 1'b0, 32'h8000_0063, 32'h9999_9999, 1'b0, 1'b0, 1'b1, 2'd0};

        for (int i = 0; i < 10; i++) begin
            step();
            drive_m(vecs[i].en, vecs[i].wen, vecs[i].size, vecs[i].addr, vecs[i].wdata);
            flush_exceptM = vecs[i].flush;
            #1;
            chk1($sformatf("vec%0d_req", i), bus_if.data_req, vecs[i].exp_req);
            chk1($sformatf("vec%0d_stall", i), d_stall, vecs[i].exp_stall);
            chk1($sformatf("vec%0d_wr", i), bus_if.data_wr, vecs[i].exp_wr);
            chk($sformatf("vec%0d_size", i), 32'(bus_if.data_size), 32'(vecs[i].exp_size));
            chk($sformatf("vec%0d_addr", i), bus_if.data_addr, vecs[i].addr);
            chk($sformatf("vec%0d_wdata", i), bus_if.data_wdata, vecs[i].wdata);
            // Withdraw before the edge so the FSM stays in IDLE.
            mem_enM       = 1'b0;
            flush_exceptM = 1'b0;
        end
        chk("table_no_accept", 32'(bus_acc), 32'd0);

        // ---------------- load word, minimum latency ----------------
        acc0 = bus_acc;
        step();
        drive_m(1'b1, 4'b0000, 2'd2, 32'h8000_0010, 32'h0);
        bus_if.data_addr_ok = 1'b1;
        #1;
        chk1("lw_c0_req", bus_if.data_req, 1'b1);
        chk1("lw_c0_stall", d_stall, 1'b1);
        step();
        bus_if.data_addr_ok = 1'b0;
        bus_if.data_data_ok = 1'b1;
        bus_if.data_rdata   = 32'hDEAD_BEEF;
        #1;
        chk1("lw_c1_req", bus_if.data_req, 1'b0);
        chk1("lw_c1_stall", d_stall, 1'b1);
        step();
        bus_if.data_data_ok = 1'b0;
        bus_if.data_rdata   = 32'h0;
        #1;
        chk1("lw_done_stall", d_stall, 1'b0);
        chk1("lw_done_no_reissue", bus_if.data_req, 1'b0);
        chk("lw_done_rdata", mem_rdataM2, 32'hDEAD_BEEF);
        step();
        mem_enM = 1'b0;
        #1;
        chk1("lw_idle_stall", d_stall, 1'b0);
        chk("lw_one_accept", 32'(bus_acc - acc0), 32'd1);

        // ---------------- store byte, addr_ok after 3 wait cycles ----------------
        acc0 = bus_acc;
        for (int i = 0; i < 4; i++) begin
            step();
            drive_m(1'b1, 4'b0100, 2'd2, 32'h8000_0012, 32'h5A5A_5A5A);
            bus_if.data_addr_ok = (i == 3);
            #1;
            chk1($sformatf("sb_c%0d_req", i), bus_if.data_req, 1'b1);
            chk1($sformatf("sb_c%0d_stall", i), d_stall, 1'b1);
            chk1($sformatf("sb_c%0d_wr", i), bus_if.data_wr, 1'b1);
            chk($sformatf("sb_c%0d_size", i), 32'(bus_if.data_size), 32'd0);
            chk($sformatf("sb_c%0d_addr", i), bus_if.data_addr, 32'h8000_0012);
            chk($sformatf("sb_c%0d_wdata", i), bus_if.data_wdata, 32'h5A5A_5A5A);
        end
        step();
        bus_if.data_addr_ok = 1'b0;
        bus_if.data_data_ok = 1'b1;
        bus_if.data_rdata   = 32'hBAD0_BAD0;
        #1;
        chk1("sb_wait_req", bus_if.data_req, 1'b0);
        chk1("sb_wait_stall", d_stall, 1'b1);
        step();
        bus_if.data_data_ok = 1'b0;
        #1;
        chk1("sb_done_stall", d_stall, 1'b0);
        chk("sb_rdata_kept", mem_rdataM2, 32'hDEAD_BEEF);
        step();
        mem_enM = 1'b0;
        #1;
        chk("sb_one_accept", 32'(bus_acc - acc0), 32'd1);

        // ---------------- flush before accept ----------------
        acc0 = bus_acc;
        step();
        drive_m(1'b1, 4'b0000, 2'd2, 32'h8000_0040, 32'h0);
        #1;
        chk1("fb_c0_req", bus_if.data_req, 1'b1);
        step();
        flush_exceptM = 1'b1;
        #1;
        chk1("fb_wa_req_dropped", bus_if.data_req, 1'b0);
        chk1("fb_wa_stall", d_stall, 1'b1);
        step();
        flush_exceptM = 1'b0;
        mem_enM       = 1'b0;
        #1;
        chk1("fb_idle_stall", d_stall, 1'b0);
        chk1("fb_idle_req", bus_if.data_req, 1'b0);
        chk("fb_no_accept", 32'(bus_acc - acc0), 32'd0);

        // ---------------- flush after accept (kill flag) ----------------
        step();
        drive_m(1'b1, 4'b0000, 2'd2, 32'h8000_0044, 32'h0);
        bus_if.data_addr_ok = 1'b1;
        #1;
        chk1("fa_c0_req", bus_if.data_req, 1'b1);
        step();
        bus_if.data_addr_ok = 1'b0;
        flush_exceptM       = 1'b1;
        #1;
        chk1("fa_wd_stall", d_stall, 1'b1);
        step();
        flush_exceptM       = 1'b0;
        bus_if.data_data_ok = 1'b1;
        bus_if.data_rdata   = 32'h1234_5678;
        #1;
        chk1("fa_wd2_stall", d_stall, 1'b1);
        step();
        bus_if.data_data_ok = 1'b0;
        bus_if.data_rdata   = 32'h0;
        #1;
        // In IDLE a live start requests at once; in DONE it would not.
        chk1("fa_idle_not_done_req", bus_if.data_req, 1'b1);
        chk1("fa_idle_not_done_stall", d_stall, 1'b1);
        chk("fa_rdata_discarded", mem_rdataM2, 32'hDEAD_BEEF);
        mem_enM = 1'b0;

        // ---------------- reset mid-transaction ----------------
        step();
        drive_m(1'b1, 4'b0000, 2'd2, 32'h8000_0048, 32'h0);
        bus_if.data_addr_ok = 1'b1;
        step();
        bus_if.data_addr_ok = 1'b0;
        rst = 1'b1;
        step();
        rst     = 1'b0;
        mem_enM = 1'b0;
        #1;
        chk1("rst_mid_stall", d_stall, 1'b0);
        chk("rst_mid_rdata", mem_rdataM2, 32'h0);

        // ---------------- held pipeline after completion ----------------
        acc0 = bus_acc;
        step();
        drive_m(1'b1, 4'b0000, 2'd2, 32'h8000_0020, 32'h0);
        bus_if.data_addr_ok = 1'b1;
        step();
        bus_if.data_addr_ok = 1'b0;
        bus_if.data_data_ok = 1'b1;
        bus_if.data_rdata   = 32'hCAFE_F00D;
        for (int i = 0; i < 5; i++) begin
            step();
            bus_if.data_data_ok = 1'b0;
            longest_stall       = 1'b1;
            #1;
            chk1($sformatf("hold_c%0d_stall", i), d_stall, 1'b0);
            chk1($sformatf("hold_c%0d_req", i), bus_if.data_req, 1'b0);
            chk($sformatf("hold_c%0d_rdata", i), mem_rdataM2, 32'hCAFE_F00D);
        end
        step();
        longest_stall = 1'b0;
        #1;
        chk1("hold_release_stall", d_stall, 1'b0);
        step();
        #1;
        chk1("hold_idle_req", bus_if.data_req, 1'b1);
        mem_enM = 1'b0;
        chk("hold_one_accept", 32'(bus_acc - acc0), 32'd1);
`ifdef D_BRIDGE_PERF_EN
        chk("perf_acc", perf_acc_cnt, 32'd1);
        chk("perf_stall", perf_stall_cnt, 32'd2);
`endif

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
